seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/sat_counter.sv | 21 ++
 rtl/seq_detect_param.sv | 63 ++++++
 tb/tb_seq_detect_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared limits, default pattern and fill-count type for the serial pattern detector.
package seq_detect_pkg;

   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 16;
   localparam int DEF_PAT_LEN = 5;
   localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b11101;
   localparam int FILL_W = $clog2(PAT_LEN_MAX);

   // Sized for the widest legal pattern so every instance shares one type.
   typedef logic [FILL_W-1:0] fill_t;

   function automatic fill_t fill_next(input fill_t f, input fill_t full);
      return (f == full) ? full : f + 1'b1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter, one step per cycle with inc high.
module sat_counter #(
   parameter int CNT_W = 8
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clock or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;

   assign count = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: Mealy serial pattern detector with optional overlap.
// Define SEQ_DETECT_COUNT_EN to add the saturating match_count output.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int PAT_LEN = DEF_PAT_LEN,
   parameter     PATTERN = DEF_PATTERN,
   parameter bit OVERLAP = 1'b1,
   parameter int CNT_W   = 8
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             datain,
   input  logic             valid,
   input  logic             clear,
   output logic             dataout
`ifdef SEQ_DETECT_COUNT_EN
  ,output logic [CNT_W-1:0] match_count
`endif
);

   localparam int HW = PAT_LEN - 1;
   localparam logic [PAT_LEN-1:0] PAT = PAT_LEN'(PATTERN);
   localparam fill_t FULL = fill_t'(HW);

   generate
      if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX || (PATTERN >> PAT_LEN) != '0 || CNT_W < 1) begin : g_bad_cfg
         $error("seq_detect_param: illegal PAT_LEN/PATTERN/CNT_W configuration");
      end
   endgenerate

   logic [HW-1:0] hist_q, hist_d;
   fill_t         fill_q, fill_d;
   logic          take, hit;

   // A full window of history is required before any compare can count.
   always_comb begin
      take    = valid && !clear;
      hit     = ({hist_q, datain} == PAT) && (fill_q == FULL);
      dataout = take && hit && !reset;
      hist_d  = clear ? '0 : take ? HW'({hist_q, datain}) : hist_q;
      fill_d  = clear ? '0 : !take ? fill_q : (hit && !OVERLAP) ? '0 : fill_next(fill_q, FULL);
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end

`ifdef SEQ_DETECT_COUNT_EN
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (dataout),
      .count (match_count)
   );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: table vectors, corner sequences and random stimulus against a queue-based model.
module tb_seq_detect_param;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic datain = 1'b0;
   logic valid = 1'b0;
   logic clear = 1'b0;
   logic dout0, dout1, dout2;
`ifdef SEQ_DETECT_COUNT_EN
   logic [7:0] mc0, mc1, mc2;
   logic [1:0] mc3;
   logic       dout3;
`endif

   always #5 clock = ~clock;

   seq_detect_param u0 (
      .clock(clock), .reset(reset), .datain(datain), .valid(valid), .clear(clear), .dataout(dout0)
`ifdef SEQ_DETECT_COUNT_EN
     ,.match_count(mc0)
`endif
   );

   seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u1 (
      .clock(clock), .reset(reset), .datain(datain), .valid(valid), .clear(clear), .dataout(dout1)
`ifdef SEQ_DETECT_COUNT_EN
     ,.match_count(mc1)
`endif
   );

   seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) u2 (
      .clock(clock), .reset(reset), .datain(datain), .valid(valid), .clear(clear), .dataout(dout2)
`ifdef SEQ_DETECT_COUNT_EN
     ,.match_count(mc2)
`endif
   );

`ifdef SEQ_DETECT_COUNT_EN
   seq_detect_param #(.CNT_W(2)) u3 (
      .clock(clock), .reset(reset), .datain(datain), .valid(valid), .clear(clear), .dataout(dout3),
      .match_count(mc3)
   );
`endif

   int passed = 0;
   int total  = 0;

   // Reference model: each detector is a queue of the bits it may still use.
   bit mq [3][$];
   int mlen [3] = '{5, 4, 4};
   int mpat [3] = '{'b11101, 'b1101, 'b1101};
   bit mov  [3] = '{1'b1, 1'b1, 1'b0};
   int cnt0 = 0;
   int cnt3 = 0;

   typedef struct {
      bit d, v, c;
      int e0, e1, e2;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic bit mhit(input int k, input bit d);
      int w = 0;
      if (mq[k].size() != mlen[k] - 1) return 1'b0;
      foreach (mq[k][i]) w = (w << 1) | int'(mq[k][i]);
      w = (w << 1) | int'(d);
      return w == mpat[k];
   endfunction

   task automatic check_counts();
`ifdef SEQ_DETECT_COUNT_EN
      chk("count8", int'(mc0), cnt0);
      chk("count2", int'(mc3), cnt3);
`endif
   endtask

   task automatic step(input bit d, input bit v, input bit c, input int e0, input int e1, input int e2);
      bit h [3];
      int act [3];
      int e [3];
      @(negedge clock);
      datain = d;
      valid  = v;
      clear  = c;
      #1;
      act = '{int'(dout0), int'(dout1), int'(dout2)};
      e   = '{e0, e1, e2};
      for (int k = 0; k < 3; k++) begin
         h[k] = v && !c && mhit(k, d);
         chk($sformatf("model_dout%0d", k), act[k], int'(h[k]));
         if (e[k] >= 0) chk($sformatf("table_dout%0d", k), act[k], e[k]);
      end
      @(posedge clock);
      for (int k = 0; k < 3; k++) begin
         if (c) mq[k].delete();
         else if (v) begin
            mq[k].push_back(d);
            if (h[k] && !mov[k]) mq[k].delete();
            else if (mq[k].size() > mlen[k] - 1) void'(mq[k].pop_front());
         end
      end
      if (h[0]) begin
         cnt0 = (cnt0 < 255) ? cnt0 + 1 : 255;
         cnt3 = (cnt3 < 3) ? cnt3 + 1 : 3;
      end
      #1;
      check_counts();
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      #1 reset = 1'b1;
      #1 chk("reset_dout", int'(dout0), 0);
      #1 reset = 1'b0;
      for (int k = 0; k < 3; k++) mq[k].delete();
      cnt0 = 0;
      cnt3 = 0;
      check_counts();
   endtask

   task automatic add(input bit d, input bit v, input bit c, input int e0, input int e1, input int e2);
      vec_t r;
      r.d = d; r.v = v; r.c = c; r.e0 = e0; r.e1 = e1; r.e2 = e2;
      tbl.push_back(r);
   endtask

   initial begin
      // Basic stream with overlapping default matches on bits 5 and 9
      add(0,0,1, 0,0,0);
      add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(0,1,0, 0,0,0);
      add(1,1,0, 1,1,1); add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(0,1,0, 0,0,0);
      add(1,1,0, 1,1,1);
      // Overlap vs non-overlap on 1101
      add(0,0,1, 0,0,0);
      add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(0,1,0, 0,0,0); add(1,1,0, 0,1,1);
      add(1,1,0, 0,0,0); add(0,1,0, 0,0,0); add(1,1,0, 0,1,0);
      // valid=0 gaps hold state
      add(0,0,1, 0,0,0);
      add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,1,0, 0,0,0);
      add(1,0,0, 0,0,0); add(0,0,0, 0,0,0); add(1,0,0, 0,0,0);
      add(0,1,0, 0,0,0); add(1,1,0, 1,1,1);
      // clear beats valid and empties history
      add(0,0,1, 0,0,0);
      add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(0,1,0, 0,0,0);
      add(1,1,1, 0,0,0); add(1,1,0, 0,0,0);
      add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,1,0, 0,0,0); add(0,1,0, 0,0,0);
      add(1,1,0, 1,1,1);

      reset  = 1'b1;
      valid  = 1'b1;
      datain = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_dout0", int'(dout0), 0);
      chk("reset_dout1", int'(dout1), 0);
      check_counts();
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].d, tbl[i].v, tbl[i].c, tbl[i].e0, tbl[i].e1, tbl[i].e2);

      // Async reset mid-pattern discards the partial match
      step(0,0,1, 0,0,0);
      step(1,1,0, 0,0,0); step(1,1,0, 0,0,0); step(1,1,0, 0,0,0); step(0,1,0, 0,0,0);
      pulse_reset();
      step(1,1,0, 0,0,0);
      step(1,1,0, 0,0,0); step(1,1,0, 0,0,0); step(1,1,0, 0,0,0); step(0,1,0, 0,0,0);
      step(1,1,0, 1,1,1);

      // Five back-to-back default matches drive the 2-bit counter into saturation
      for (int m = 0; m < 5; m++) begin
         step(1,1,0, -1,-1,-1); step(1,1,0, -1,-1,-1); step(1,1,0, -1,-1,-1);
         step(0,1,0, -1,-1,-1); step(1,1,0, -1,-1,-1); step(0,0,1, 0,0,0);
      end

      repeat (400)
         step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0),
              bit'($urandom_range(0, 15) == 0), -1, -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
